// File: rtl/elevator_controller.sv
// rtl/elevator_controller.sv - SCAN-policy sequencing FSM for one elevator car
// Drives one-floor step pulses and the door-open level from the datapath's request summary flags.
module elevator_controller #(
   parameter int MOVE_CYCLES = 8,
   parameter int DOOR_CYCLES = 16,
   parameter int TIMER_W     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       request_i,
   input  logic       request_j_gt_i,
   input  logic       request_j_lt_i,
   input  logic       at_top,
   input  logic       at_bottom,
   input  logic       door_hold,
   output logic       up,
   output logic       down,
   output logic       open,
   output logic       dir_up,
   output logic       busy,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DOOR    = 3'd1,
      MOVE_UP = 3'd2,
      MOVE_DN = 3'd3,
      STEP_UP = 3'd4,
      STEP_DN = 3'd5
   } state_t;

   localparam logic [TIMER_W-1:0] MOVE_LOAD = TIMER_W'(MOVE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_CYCLES - 1);

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               dir_up_q, dir_up_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         dir_up_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         dir_up_q <= dir_up_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      dir_up_d = dir_up_q;
      case (state_q)
         IDLE: begin
            // Serve the current floor first, then keep scanning in the current direction.
            if (request_i) begin
               state_d = DOOR;
               timer_d = DOOR_LOAD;
            end else if (dir_up_q && request_j_gt_i && !at_top) begin
               state_d = MOVE_UP;
               timer_d = MOVE_LOAD;
            end else if (dir_up_q && request_j_lt_i && !at_bottom) begin
               state_d  = MOVE_DN;
               timer_d  = MOVE_LOAD;
               dir_up_d = 1'b0;
            end else if (!dir_up_q && request_j_lt_i && !at_bottom) begin
               state_d = MOVE_DN;
               timer_d = MOVE_LOAD;
            end else if (!dir_up_q && request_j_gt_i && !at_top) begin
               state_d  = MOVE_UP;
               timer_d  = MOVE_LOAD;
               dir_up_d = 1'b1;
            end
         end
         DOOR: begin
            if (door_hold) begin
               timer_d = DOOR_LOAD;
            end else if (timer_q == '0) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         MOVE_UP: begin
            // Never step past the end of the shaft, even if the datapath still reports requests.
            if (at_top) begin
               state_d = IDLE;
            end else if (timer_q == '0) begin
               state_d = STEP_UP;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         MOVE_DN: begin
            if (at_bottom) begin
               state_d = IDLE;
            end else if (timer_q == '0) begin
               state_d = STEP_DN;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         STEP_UP: state_d = IDLE;
         STEP_DN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign open   = (state_q == DOOR);
   assign up     = (state_q == STEP_UP);
   assign down   = (state_q == STEP_DN);
   assign busy   = (state_q != IDLE);
   assign dir_up = dir_up_q;
   assign state  = state_q;

endmodule
